// File: rtl/decode_stage.sv
// Registered MIPS decode: insn/pc in, decoded fields out one cycle later (latency 1).
// Backpressure: in_ready = !out_valid || out_ready, no skid buffer; flush drops the held beat.
module decode_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int CNT_WIDTH     = 16,
    parameter bit NOP_AS_BUBBLE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [0:31]           insn,
    input  logic [0:31]           pc,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [5:0]            out_id,
    output logic [4:0]            out_rs,
    output logic [4:0]            out_rt,
    output logic [4:0]            out_dest,
    output logic                  out_reg_write,
    output logic                  out_mem_read,
    output logic                  out_mem_write,
    output logic [DATA_WIDTH-1:0] out_imm,
    output logic [0:31]           out_target,
    output logic [0:31]           out_pc,
    output logic [CNT_WIDTH-1:0]  insn_count,
    output logic [CNT_WIDTH-1:0]  illegal_count
);

    localparam logic [5:0] ID_NOP   = 6'd0,  ID_ADD   = 6'd1,  ID_MULT  = 6'd5;
    localparam logic [5:0] ID_MFHI  = 6'd9,  ID_MFLO  = 6'd10, ID_SLT   = 6'd11;
    localparam logic [5:0] ID_SLTU  = 6'd12, ID_SLL   = 6'd13, ID_SLLV  = 6'd14;
    localparam logic [5:0] ID_SRL   = 6'd15, ID_SRLV  = 6'd16, ID_SRA   = 6'd17;
    localparam logic [5:0] ID_SRAV  = 6'd18, ID_AND   = 6'd19, ID_JALR  = 6'd23;
    localparam logic [5:0] ID_JR    = 6'd24, ID_ADDIU = 6'd25, ID_SLTI  = 6'd26;
    localparam logic [5:0] ID_SLTIU = 6'd27, ID_ORI   = 6'd28, ID_XORI  = 6'd29;
    localparam logic [5:0] ID_LW    = 6'd30, ID_SW    = 6'd31, ID_LUI   = 6'd32;
    localparam logic [5:0] ID_LB    = 6'd33, ID_SB    = 6'd34, ID_LBU   = 6'd35;
    localparam logic [5:0] ID_J     = 6'd36, ID_JAL   = 6'd37, ID_BEQ   = 6'd38;
    localparam logic [5:0] ID_BNE   = 6'd39, ID_BLTZ  = 6'd40, ID_BGEZ  = 6'd41;
    localparam logic [5:0] ID_BGTZ  = 6'd42, ID_BLEZ  = 6'd43, ID_ILLEGAL = 6'd63;

    // Conventional little-endian views so field slicing matches the MIPS manual.
    logic [31:0] insn_w, pc_w, pc4, br_tgt, j_tgt;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, sa;
    logic [15:0] imm16;
    logic [DATA_WIDTH-1:0] imm_sext, imm_zext, imm_lui, imm_sa;

    assign insn_w   = insn;
    assign pc_w     = pc;
    assign opcode   = insn_w[31:26];
    assign rs       = insn_w[25:21];
    assign rt       = insn_w[20:16];
    assign rd       = insn_w[15:11];
    assign sa       = insn_w[10:6];
    assign funct    = insn_w[5:0];
    assign imm16    = insn_w[15:0];
    assign pc4      = pc_w + 32'd4;
    assign br_tgt   = pc4 + {{14{imm16[15]}}, imm16, 2'b00};
    assign j_tgt    = {pc4[31:28], insn_w[25:0], 2'b00};
    assign imm_sext = DATA_WIDTH'($signed(imm16));
    assign imm_zext = DATA_WIDTH'(imm16);
    assign imm_lui  = DATA_WIDTH'({imm16, 16'h0000});
    assign imm_sa   = DATA_WIDTH'(sa);

    logic [5:0]            dec_id;
    logic [4:0]            dec_dest;
    logic                  dec_wr, dec_mrd, dec_mwr;
    logic [DATA_WIDTH-1:0] dec_imm;
    logic [31:0]           dec_tgt;

    always_comb begin
        dec_id   = ID_ILLEGAL;
        dec_dest = 5'd0;
        dec_wr   = 1'b0;
        dec_mrd  = 1'b0;
        dec_mwr  = 1'b0;
        dec_imm  = '0;
        dec_tgt  = 32'd0;
        case (opcode)
            6'b000000: begin
                dec_wr = 1'b1;
                case (funct)
                    6'b000000: begin dec_id = ID_SLL; dec_imm = imm_sa; end
                    6'b000010: begin dec_id = ID_SRL; dec_imm = imm_sa; end
                    6'b000011: begin dec_id = ID_SRA; dec_imm = imm_sa; end
                    6'b000100: dec_id = ID_SLLV;
                    6'b000110: dec_id = ID_SRLV;
                    6'b000111: dec_id = ID_SRAV;
                    6'b001000: begin dec_id = ID_JR; dec_wr = 1'b0; end
                    6'b001001: dec_id = ID_JALR;
                    6'b010000: dec_id = ID_MFHI;
                    6'b010010: dec_id = ID_MFLO;
                    6'b011000, 6'b011001, 6'b011010, 6'b011011: begin
                        dec_id = ID_MULT + {4'd0, funct[1:0]};
                        dec_wr = 1'b0;
                    end
                    6'b100000, 6'b100001, 6'b100010, 6'b100011:
                        dec_id = ID_ADD + {4'd0, funct[1:0]};
                    6'b100100, 6'b100101, 6'b100110, 6'b100111:
                        dec_id = ID_AND + {4'd0, funct[1:0]};
                    6'b101010: dec_id = ID_SLT;
                    6'b101011: dec_id = ID_SLTU;
                    default:   dec_wr = 1'b0;
                endcase
                if (insn_w == 32'd0) begin
                    dec_id  = ID_NOP;
                    dec_imm = '0;
                end
                if (dec_wr) dec_dest = rd;
            end
            6'b000001: begin
                if (rt[4:1] == 4'd0) begin
                    dec_id  = rt[0] ? ID_BGEZ : ID_BLTZ;
                    dec_imm = imm_sext;
                    dec_tgt = br_tgt;
                end
            end
            6'b000010: begin dec_id = ID_J; dec_tgt = j_tgt; end
            6'b000011: begin
                dec_id = ID_JAL; dec_tgt = j_tgt; dec_dest = 5'd31; dec_wr = 1'b1;
            end
            6'b000100, 6'b000101, 6'b000110, 6'b000111: begin
                case (opcode[1:0])
                    2'b00:   dec_id = ID_BEQ;
                    2'b01:   dec_id = ID_BNE;
                    2'b10:   dec_id = ID_BLEZ;
                    default: dec_id = ID_BGTZ;
                endcase
                dec_imm = imm_sext;
                dec_tgt = br_tgt;
            end
            6'b001001: begin dec_id = ID_ADDIU; dec_imm = imm_sext; dec_dest = rt; dec_wr = 1'b1; end
            6'b001010: begin dec_id = ID_SLTI;  dec_imm = imm_sext; dec_dest = rt; dec_wr = 1'b1; end
            6'b001011: begin dec_id = ID_SLTIU; dec_imm = imm_sext; dec_dest = rt; dec_wr = 1'b1; end
            6'b001101: begin dec_id = ID_ORI;   dec_imm = imm_zext; dec_dest = rt; dec_wr = 1'b1; end
            6'b001110: begin dec_id = ID_XORI;  dec_imm = imm_zext; dec_dest = rt; dec_wr = 1'b1; end
            6'b001111: begin dec_id = ID_LUI;   dec_imm = imm_lui;  dec_dest = rt; dec_wr = 1'b1; end
            6'b100000, 6'b100011, 6'b100100: begin
                dec_id   = (opcode == 6'b100000) ? ID_LB : (opcode == 6'b100011) ? ID_LW : ID_LBU;
                dec_imm  = imm_sext;
                dec_dest = rt;
                dec_wr   = 1'b1;
                dec_mrd  = 1'b1;
            end
            6'b101000, 6'b101011: begin
                dec_id  = opcode[1] ? ID_SW : ID_SB;
                dec_imm = imm_sext;
                dec_mwr = 1'b1;
            end
            default: ;
        endcase
        if (dec_dest == 5'd0) dec_wr = 1'b0;
    end

    logic                  valid_q, valid_d;
    logic [5:0]            id_q, id_d;
    logic [4:0]            rs_q, rs_d, rt_q, rt_d, dest_q, dest_d;
    logic                  reg_write_q, reg_write_d, mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic [DATA_WIDTH-1:0] imm_q, imm_d;
    logic [31:0]           target_q, target_d, pc_q, pc_d;
    logic [CNT_WIDTH-1:0]  insn_cnt_q, insn_cnt_d, ill_cnt_q, ill_cnt_d;
    logic                  accept, bubble, load;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign bubble   = NOP_AS_BUBBLE && (insn_w == 32'd0);
    assign load     = accept && !bubble;

    always_comb begin
        valid_d     = valid_q;
        id_d        = id_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        dest_d      = dest_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        imm_d       = imm_q;
        target_d    = target_q;
        pc_d        = pc_q;
        insn_cnt_d  = insn_cnt_q;
        ill_cnt_d   = ill_cnt_q;
        if (flush)
            valid_d = 1'b0;
        else if (accept)
            valid_d = !bubble;
        else if (out_ready)
            valid_d = 1'b0;
        if (load) begin
            id_d        = dec_id;
            rs_d        = rs;
            rt_d        = rt;
            dest_d      = dec_dest;
            reg_write_d = dec_wr;
            mem_read_d  = dec_mrd;
            mem_write_d = dec_mwr;
            imm_d       = dec_imm;
            target_d    = dec_tgt;
            pc_d        = pc_w;
            if (insn_cnt_q != '1) insn_cnt_d = insn_cnt_q + CNT_WIDTH'(1);
            if (dec_id == ID_ILLEGAL && ill_cnt_q != '1) ill_cnt_d = ill_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            id_q        <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            dest_q      <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            imm_q       <= '0;
            target_q    <= '0;
            pc_q        <= '0;
            insn_cnt_q  <= '0;
            ill_cnt_q   <= '0;
        end else begin
            valid_q     <= valid_d;
            id_q        <= id_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            dest_q      <= dest_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            imm_q       <= imm_d;
            target_q    <= target_d;
            pc_q        <= pc_d;
            insn_cnt_q  <= insn_cnt_d;
            ill_cnt_q   <= ill_cnt_d;
        end
    end

    assign out_valid     = valid_q;
    assign out_id        = id_q;
    assign out_rs        = rs_q;
    assign out_rt        = rt_q;
    assign out_dest      = dest_q;
    assign out_reg_write = reg_write_q;
    assign out_mem_read  = mem_read_q;
    assign out_mem_write = mem_write_q;
    assign out_imm       = imm_q;
    assign out_target    = target_q;
    assign out_pc        = pc_q;
    assign insn_count    = insn_cnt_q;
    assign illegal_count = ill_cnt_q;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered MIPS instruction decode stage with a valid/ready handshake on both sides.
- Sits between fetch and execute. Converts a 32-bit instruction word and its PC into an enumerated instruction ID, register indices, an extended immediate, a branch/jump target and control flags.
- Replaces print-only decoding with a real pipeline register, flush support, illegal-instruction detection and saturating statistics counters.

Parameters:
DATA_WIDTH, 32, width of the extended immediate output; legal values are 32 or more; sign/zero extension fills bits above 16.
CNT_WIDTH, 16, width of the insn_count and illegal_count statistics counters.
NOP_AS_BUBBLE, 1, 1 = an all-zero instruction is consumed but produces no output beat; 0 = it is emitted with id NOP.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  insn/pc valid
in_ready  out  1  stage can accept this cycle
insn  in  [0:31]  instruction word; bit 0 is MSB, opcode = insn[0:5]
pc  in  [0:31]  address of insn
flush  in  1  discard the held output and any input this cycle
out_valid  out  1  decoded beat valid
out_ready  in  1  downstream accepts
out_id  out  6  enumerated instruction ID
out_rs  out  5  insn[6:10]
out_rt  out  5  insn[11:15]
out_dest  out  5  destination register
out_reg_write  out  1  writes GPR; forced 0 when out_dest==0
out_mem_read  out  1  LW/LB/LBU
out_mem_write  out  1  SW/SB
out_imm  out  DATA_WIDTH  extended immediate or shift amount
out_target  out  [0:31]  branch/jump target
out_pc  out  [0:31]  registered pc
insn_count  out  CNT_WIDTH  accepted non-bubble instructions, saturating
illegal_count  out  CNT_WIDTH  accepted ILLEGAL instructions, saturating

Behaviour:
- Reset: all outputs 0, out_valid=0, counters 0, in_ready=1. Reset is asynchronous on assertion and takes effect mid-transfer; any held beat is lost.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational). No skid buffer.
  - Accept when in_valid && in_ready && !flush.
  - Latency is 1 cycle: the accepted beat appears on the out_* registers next edge with out_valid=1.
  - Outputs hold stable while out_valid && !out_ready.
  - out_valid clears after a transfer with no new accept.
- flush: the next edge sets out_valid=0 and no capture occurs, whatever in_valid/out_ready are. Counters do not increment.
- Bubble: if NOP_AS_BUBBLE=1 and insn==0, the beat is consumed, out_valid is not set and insn_count is unchanged.
- Instruction IDs:
  - 0 NOP, 1 ADD, 2 ADDU, 3 SUB, 4 SUBU, 5 MULT, 6 MULTU, 7 DIV, 8 DIVU, 9 MFHI, 10 MFLO.
  - 11 SLT, 12 SLTU, 13 SLL, 14 SLLV, 15 SRL, 16 SRLV, 17 SRA, 18 SRAV, 19 AND, 20 OR, 21 XOR, 22 NOR, 23 JALR, 24 JR.
  - 25 ADDIU, 26 SLTI, 27 SLTIU, 28 ORI, 29 XORI, 30 LW, 31 SW, 32 LUI, 33 LB, 34 SB, 35 LBU.
  - 36 J, 37 JAL, 38 BEQ, 39 BNE, 40 BLTZ, 41 BGEZ, 42 BGTZ, 43 BLEZ, 63 ILLEGAL.
- SPECIAL (opcode 0) funct codes: SLL 000000, SRL 000010, SRA 000011, SLLV 000100, SRLV 000110, SRAV 000111, JR 001000, JALR 001001, MFHI 010000, MFLO 010010, MULT..DIVU 011000..011011, ADD..SUBU 100000..100011, AND/OR/XOR/NOR 100100..100111, SLT 101010, SLTU 101011.
- Any other funct, or any unlisted opcode, decodes to ILLEGAL; REGIMM (opcode 000001) with rt not 0 or 1 is also ILLEGAL.
- ILLEGAL beats are emitted with all write/mem flags 0 and increment illegal_count; this counter is independent of insn_count.
- out_dest:
  - rd for R-type writers (ALU ops, shifts, MFHI/MFLO, JALR).
  - rt for ADDIU, SLTI, SLTIU, ORI, XORI, LUI and loads.
  - 31 for JAL.
  - 0 with reg_write=0 for MULT/DIV family, JR, stores, branches and J.
- out_imm:
  - Sign-extended insn[16:31] for ADDIU, SLTI, SLTIU, loads, stores and branches.
  - Zero-extended for ORI and XORI.
  - insn[16:31]<<16 for LUI.
  - Zero-extended sa (insn[21:25]) for SLL/SRL/SRA.
  - 0 otherwise.
- out_target (32-bit modulo arithmetic):
  - Branches: pc+4+(sext(offset)<<2).
  - J/JAL: {(pc+4)[0:3], insn[6:31], 2'b00}.
  - 0 otherwise.
- Counters saturate at all-ones and never wrap.

Test Plan:
- Reset then insn=0x00851020 (ADD rs4 rt5 rd2), pc=0x100, out_ready=1 -> one cycle later: out_valid=1, id=1, rs=4, rt=5, dest=2, reg_write=1, insn_count=1.
- insn=0x1000FFFF (BEQ offset −1), pc=0x200 -> id=38, target=0x200, imm=0xFFFFFFFF, reg_write=0.
- insn=0x0C000040 (JAL), pc=0x80000010 -> id=37, dest=31, target=0x80000100; insn=0x3402FFFF (ORI) -> imm=0x0000FFFF.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable; release -> next beat follows with no loss or duplication. Assert flush with a beat held -> out_valid=0 next edge, counters unchanged.
- insn=0 with NOP_AS_BUBBLE=1 -> no out_valid, insn_count unchanged; insn=0xFC000000 -> id=63, illegal_count=1. CNT_WIDTH=2 with 5 accepts -> insn_count holds at 3.
- Drop rst_n asynchronously between edges while out_valid=1 -> outputs and counters clear immediately, in_ready=1.
